dsm_decimator: RTL and testbench



---
 rtl/dsm_pkg.sv | 19 +
 rtl/dsm_cic_comb.sv | 38 +++
 rtl/dsm_decimator.sv | 166 ++++++++++++++++
 tb/tb_dsm_decimator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma link (modulator, decimator, benches).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dsm_pkg;

  // Sample width carried on the link, shared by dsm.vin and dsm_decimator.vout.
  localparam int VIN_W = 20;

  // Number of integrator/comb pairs in the sinc^N reconstruction filter.
  localparam int CIC_ORDER = 3;

  // Accumulator width that holds the full CIC gain R^N = 2^(N*log2R) without
  // ambiguity. One extra bit keeps the full-scale result (exactly R^N) from
  // aliasing to zero in modulo arithmetic.
  function automatic int cic_acc_width(input int dec_log2);
    return CIC_ORDER * dec_log2 + 1;
  endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// One CIC differentiator: y = x - x(previous decimated sample), modulo 2^AW.
// Latency: y_o is combinational from x_i; the delay tap updates on en_i edges.
// Backpressure: none; en_i marks a decimated sample and must not be stalled.
module dsm_cic_comb #(
  parameter int AW = 19
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [AW-1:0] x_i,
  output logic [AW-1:0] y_o
);

  logic [AW-1:0] dly_q;
  logic [AW-1:0] dly_d;

  // Wrap-around subtraction is intended: the integrators overflow freely and
  // the differentiator undoes it exactly as long as AW covers the filter gain.
  assign y_o = x_i - dly_q;

  // Delay tap advances by one decimated sample whenever the strobe fires.
  always_comb begin
    dly_d = dly_q;
    if (en_i) begin
      dly_d = x_i;
    end
  end

  // Delay register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

endmodule

// File: rtl/dsm_decimator.sv
// sinc^3 CIC decimator: 1-bit pwm stream -> OUT_W-bit unsigned saturated samples.
// Latency: vout_valid pulses 3 clocks after the edge accepting a window's last sample.
// Backpressure: none; in_valid gaps stall the filter, consumer must take vout on vout_valid.
module dsm_decimator
  import dsm_pkg::*;
#(
  parameter int DEC_LOG2 = 6,
  parameter int OUT_W    = VIN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm,
  input  logic             in_valid,
  output logic [OUT_W-1:0] vout,
  output logic             vout_valid
);

  localparam int AW = cic_acc_width(DEC_LOG2);
  // Left shift that maps the CIC gain R^3 onto the output full scale 2^OUT_W.
  localparam int SH = OUT_W - CIC_ORDER * DEC_LOG2;
  localparam logic [DEC_LOG2-1:0] CNT_LAST  = '1;
  localparam logic [1:0]          WARM_DONE = 2'(CIC_ORDER);

  // Reject parameter sets whose filter gain cannot be scaled into OUT_W bits.
  generate
    if (CIC_ORDER * DEC_LOG2 > OUT_W) begin : g_bad_params
      $error("dsm_decimator: 3*DEC_LOG2 must not exceed OUT_W");
    end
    if (DEC_LOG2 < 1) begin : g_bad_ratio
      $error("dsm_decimator: DEC_LOG2 must be at least 1");
    end
  endgenerate

  // Integrator chain (input rate).
  logic [AW-1:0]       i1_q, i1_d;
  logic [AW-1:0]       i2_q, i2_d;
  logic [AW-1:0]       i3_q, i3_d;
  logic [DEC_LOG2-1:0] dec_cnt_q, dec_cnt_d;
  logic                dec_stb_q, dec_stb_d;

  // Comb chain (decimated rate).
  logic [AW-1:0]       c1, c2, c3;
  logic [AW-1:0]       c3_q, c3_d;
  logic                c3_vld_q, c3_vld_d;

  // Scaling / saturation stage.
  logic [OUT_W:0]      scaled;
  logic [OUT_W-1:0]    sat_q, sat_d;
  logic                sat_vld_q, sat_vld_d;

  // Publication stage with warm-up suppression.
  logic [1:0]          warm_cnt_q, warm_cnt_d;
  logic [OUT_W-1:0]    vout_q, vout_d;
  logic                vout_valid_q, vout_valid_d;

  // Integrators and the window counter move only on accepted samples; the
  // strobe fires the cycle after the last sample of a window is accepted.
  always_comb begin
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    dec_cnt_d = dec_cnt_q;
    dec_stb_d = 1'b0;
    if (in_valid) begin
      // Pipelined: each stage adds the previous stage's registered value.
      i1_d      = i1_q + AW'(pwm);
      i2_d      = i2_q + i1_q;
      i3_d      = i3_q + i2_q;
      dec_cnt_d = dec_cnt_q + DEC_LOG2'(1);
      dec_stb_d = (dec_cnt_q == CNT_LAST);
    end
  end

  // Three cascaded differentiators, all advancing on the decimation strobe.
  dsm_cic_comb #(.AW(AW)) u_comb1 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (dec_stb_q),
    .x_i   (i3_q),
    .y_o   (c1)
  );

  dsm_cic_comb #(.AW(AW)) u_comb2 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (dec_stb_q),
    .x_i   (c1),
    .y_o   (c2)
  );

  dsm_cic_comb #(.AW(AW)) u_comb3 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (dec_stb_q),
    .x_i   (c2),
    .y_o   (c3)
  );

  // Register the comb result on the strobe cycle.
  always_comb begin
    c3_d     = c3_q;
    c3_vld_d = dec_stb_q;
    if (dec_stb_q) begin
      c3_d = c3;
    end
  end

  // Scale the gain R^3 to 2^OUT_W and clip; only the exact full-scale result
  // (c3 == R^3) reaches the extra MSB, so clipping is a single-bit test.
  always_comb begin
    scaled    = (OUT_W + 1)'(c3_q) << SH;
    sat_d     = scaled[OUT_W] ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
    sat_vld_d = c3_vld_q;
  end

  // The first CIC_ORDER decimated outputs still contain start-up transients;
  // count them off and only then start publishing.
  always_comb begin
    vout_d       = vout_q;
    vout_valid_d = 1'b0;
    warm_cnt_d   = warm_cnt_q;
    if (sat_vld_q) begin
      if (warm_cnt_q == WARM_DONE) begin
        vout_d       = sat_q;
        vout_valid_d = 1'b1;
      end else begin
        warm_cnt_d = warm_cnt_q + 2'd1;
      end
    end
  end

  // State registers; reset wins over in_valid and discards any partial window.
  always_ff @(posedge clock) begin
    if (reset) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      dec_cnt_q    <= '0;
      dec_stb_q    <= 1'b0;
      c3_q         <= '0;
      c3_vld_q     <= 1'b0;
      sat_q        <= '0;
      sat_vld_q    <= 1'b0;
      warm_cnt_q   <= '0;
      vout_q       <= '0;
      vout_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      dec_cnt_q    <= dec_cnt_d;
      dec_stb_q    <= dec_stb_d;
      c3_q         <= c3_d;
      c3_vld_q     <= c3_vld_d;
      sat_q        <= sat_d;
      sat_vld_q    <= sat_vld_d;
      warm_cnt_q   <= warm_cnt_d;
      vout_q       <= vout_d;
      vout_valid_q <= vout_valid_d;
    end
  end

  assign vout       = vout_q;
  assign vout_valid = vout_valid_q;

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed bench for dsm_decimator (R = 64, OUT_W = 20).
// Latency: first pulse expected 3 ticks after the 256th accepted sample.
// Backpressure: in_valid gaps are exercised with a pseudo-random pattern.
module tb_dsm_decimator;

  localparam int OUT_W      = 20;
  localparam int FULL_SCALE = 1048575;
  localparam int FIRST_PULSE = 4 * 64 + 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             pwm = 1'b0;
  logic             in_valid = 1'b0;
  logic [OUT_W-1:0] vout;
  logic             vout_valid;

  int checks = 0;
  int errors = 0;

  dsm_decimator #(
    .DEC_LOG2 (6),
    .OUT_W    (OUT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pwm        (pwm),
    .in_valid   (in_valid),
    .vout       (vout),
    .vout_valid (vout_valid)
  );

  always #5 clock = ~clock;

  // Drive one input sample, then look at outputs 1 ns after the edge.
  task automatic tick(input logic p, input logic v);
    pwm      = p;
    in_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    checks++;
    if (vout !== '0) begin
      errors++;
      $display("FAIL reset_vout: got %0d expected 0", vout);
    end
    checks++;
    if (vout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b expected 0", vout_valid);
    end
    reset = 1'b0;
  endtask

  // All-zero input: published values are 0, pulses 64 apart, first at 259.
  task automatic test_zero();
    int last;
    int npulse;
    last   = -1;
    npulse = 0;
    do_reset();
    for (int t = 1; t <= 1024; t++) begin
      tick(1'b0, 1'b1);
      if (vout_valid) begin
        npulse++;
        checks++;
        if (vout !== '0) begin
          errors++;
          $display("FAIL zero_value: got %0d expected 0 at tick %0d", vout, t);
        end
        checks++;
        if (last < 0) begin
          if (t != FIRST_PULSE) begin
            errors++;
            $display("FAIL zero_first_pulse: got tick %0d expected %0d", t, FIRST_PULSE);
          end
        end else if (t - last != 64) begin
          errors++;
          $display("FAIL zero_spacing: got %0d expected 64", t - last);
        end
        last = t;
      end
    end
    checks++;
    if (npulse != 12) begin
      errors++;
      $display("FAIL zero_pulse_count: got %0d expected 12", npulse);
    end
  endtask

  // Periodic pattern with period dividing 64: every published sample is exact.
  task automatic test_steady(input string name, input int pat_len,
                             input logic [3:0] pat, input int expv, input int nticks);
    int npulse;
    int early_bad;
    int exp_cnt;
    npulse    = 0;
    early_bad = 0;
    exp_cnt   = (nticks - FIRST_PULSE) / 64 + 1;
    do_reset();
    for (int t = 1; t <= nticks; t++) begin
      tick(pat[(t - 1) % pat_len], 1'b1);
      if (t < FIRST_PULSE && (vout_valid !== 1'b0 || vout !== '0)) begin
        early_bad++;
      end
      if (vout_valid) begin
        checks++;
        if (vout !== OUT_W'(expv)) begin
          errors++;
          $display("FAIL %s_value: got %0d expected %0d at tick %0d", name, vout, expv, t);
        end
        checks++;
        if (t != FIRST_PULSE + 64 * npulse) begin
          errors++;
          $display("FAIL %s_timing: pulse at tick %0d expected %0d", name, t, FIRST_PULSE + 64 * npulse);
        end
        npulse++;
      end
    end
    checks++;
    if (early_bad != 0) begin
      errors++;
      $display("FAIL %s_warmup: %0d ticks published during warm-up, expected 0", name, early_bad);
    end
    checks++;
    if (npulse != exp_cnt) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d expected %0d", name, npulse, exp_cnt);
    end
  endtask

  // Random in_valid gaps; pwm is 0 on ignored edges, 1 on accepted ones.
  task automatic test_gaps();
    int acc;
    int expq[$];
    logic v;
    logic exp_now;
    acc = 0;
    do_reset();
    for (int t = 1; t <= 4004; t++) begin
      v = (t <= 4000) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(v, v);
      if (v) begin
        acc++;
        if (acc % 64 == 0 && acc >= 256) begin
          expq.push_back(t + 3);
        end
      end
      exp_now = (expq.size() > 0 && expq[0] == t);
      if (exp_now) begin
        void'(expq.pop_front());
      end
      if (vout_valid || exp_now) begin
        checks++;
        if (vout_valid !== exp_now) begin
          errors++;
          $display("FAIL gaps_timing: vout_valid=%0b expected %0b at tick %0d", vout_valid, exp_now, t);
        end
        checks++;
        if (exp_now && vout !== OUT_W'(FULL_SCALE)) begin
          errors++;
          $display("FAIL gaps_value: got %0d expected %0d at tick %0d", vout, FULL_SCALE, t);
        end
      end
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL gaps_missing: %0d pulses never seen, expected 0", expq.size());
    end
  endtask

  // One-clock reset 300 samples in: outputs clear, warm-up starts over.
  task automatic test_mid_reset();
    int first;
    first = -1;
    do_reset();
    for (int t = 1; t <= 300; t++) begin
      tick(1'b1, 1'b1);
    end
    checks++;
    if (vout !== OUT_W'(FULL_SCALE)) begin
      errors++;
      $display("FAIL midrst_before: got %0d expected %0d", vout, FULL_SCALE);
    end
    reset = 1'b1;
    tick(1'b1, 1'b1);
    reset = 1'b0;
    checks++;
    if (vout !== '0 || vout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got vout=%0d valid=%0b expected 0/0", vout, vout_valid);
    end
    for (int t = 1; t <= 400; t++) begin
      tick(1'b1, 1'b1);
      if (vout_valid && first < 0) begin
        first = t;
        checks++;
        if (vout !== OUT_W'(FULL_SCALE)) begin
          errors++;
          $display("FAIL midrst_value: got %0d expected %0d", vout, FULL_SCALE);
        end
      end
    end
    checks++;
    if (first != FIRST_PULSE) begin
      errors++;
      $display("FAIL midrst_first_pulse: got tick %0d expected %0d", first, FIRST_PULSE);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_steady("ones", 1, 4'b0001, FULL_SCALE, 20000);
    test_steady("half", 2, 4'b0001, 524288, 2048);
    test_steady("quarter", 4, 4'b0001, 262144, 2048);
    test_gaps();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
